// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit -- multi-cycle MULT/MULTU/DIV/DIVU engine, writer side of
// the HI/LO register-file port.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, op         request (sampled only while idle); op 00 MULT, 01 MULTU,
//                     10 DIV, 11 DIVU
//   src_a, src_b      rs / rt operands, captured once on the accept edge
//   cancel            flush in-flight op (only when MULDIV_CANCEL_EN is defined)
//   busy              high whenever the engine is not idle (pipeline stall)
//   hl_write_enable   one-cycle result-valid pulse
//   hl_data           {HI, LO}; holds the last result until the next one
//
// Build option: define MULDIV_CANCEL_EN to add the cancel port.
//
// Signed operations work on magnitudes and fix the signs at the end, so the
// multiplier and the divider are both purely unsigned.
module hilo_muldiv_unit #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
`ifdef MULDIV_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic        hl_write_enable,
  output logic [63:0] hl_data
);

  localparam int CW = $clog2(DIV_ITERS);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_SIGN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   a_q, a_d;       // |multiplicand|, or |dividend| shifting into quotient
  logic [31:0]   b_q, b_d;       // |multiplier| / |divisor|
  logic [31:0]   rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sa_q, sa_d;     // operand sign flags, always 0 for unsigned ops
  logic          sb_q, sb_d;
  logic [63:0]   hl_data_q, hl_data_d;

  logic cancel_w;
`ifdef MULDIV_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  logic        accept, is_signed, a_neg, b_neg, fits;
  logic [63:0] prod;
  logic [32:0] trial;
  logic [31:0] diff, q_fix, r_fix;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = op[1] ? S_DIV : S_MUL;
      S_MUL:   state_d = S_DONE;
      S_DIV:   if (cnt_q == CW'(DIV_ITERS - 1)) state_d = S_SIGN;
      S_SIGN:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (cancel_w && state_q != S_IDLE) state_d = S_IDLE;
  end

  // Outputs
  always_comb begin
    busy            = (state_q != S_IDLE);
    hl_write_enable = (state_q == S_DONE) && !cancel_w;
    hl_data         = hl_data_q;
  end

  // Datapath
  always_comb begin
    accept    = start && !cancel_w;
    is_signed = ~op[0];
    a_neg     = is_signed & src_a[31];
    b_neg     = is_signed & src_b[31];
    prod      = {32'b0, a_q} * {32'b0, b_q};
    // Restoring step: bring in the next dividend bit and subtract if it fits.
    trial     = {rem_q, a_q[31]};
    fits      = (trial >= {1'b0, b_q});
    diff      = trial[31:0] - b_q;
    q_fix     = (sa_q ^ sb_q) ? -a_q : a_q;
    // Remainder follows the dividend; for divide-by-zero this restores src_a.
    r_fix     = sa_q ? -rem_q : rem_q;

    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    hl_data_d = hl_data_q;

    unique case (state_q)
      S_IDLE: if (accept) begin
        a_d   = a_neg ? -src_a : src_a;
        b_d   = b_neg ? -src_b : src_b;
        sa_d  = a_neg;
        sb_d  = b_neg;
        rem_d = '0;
        cnt_d = '0;
      end
      S_MUL: if (!cancel_w) hl_data_d = (sa_q ^ sb_q) ? -prod : prod;
      S_DIV: begin
        rem_d = fits ? diff : trial[31:0];
        a_d   = {a_q[30:0], fits};
        cnt_d = cnt_q + CW'(1);
      end
      // A zero divisor leaves an all-ones quotient that the sign fix would
      // corrupt, so LO is forced.
      S_SIGN: if (!cancel_w)
        hl_data_d = {r_fix, (b_q == 32'd0) ? 32'hFFFF_FFFF : q_fix};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      hl_data_q <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      hl_data_q <= hl_data_d;
    end
  end

endmodule
